// File: rtl/ipif_resp_pkg.sv
// Shared types and widths for the IPIF master-command responder.
package ipif_resp_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT,
        ST_DATA,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ipif_mst_responder_if.sv
// Single-beat IPIF master command bus between user_logic (master) and the
// far-end bus/memory (slave).
interface ipif_mst_responder_if;
    import ipif_resp_pkg::*;

    logic              ip2bus_mstrd_req;
    logic              ip2bus_mstwr_req;
    logic [31:0]       ip2bus_mst_addr;
    logic [BE_W-1:0]   ip2bus_mst_be;
    logic              ip2bus_mst_lock;
    logic              ip2bus_mst_reset;
    logic [DATA_W-1:0] ip2bus_mstwr_d;
    logic              bus2ip_mst_cmdack;
    logic              bus2ip_mst_cmplt;
    logic              bus2ip_mst_error;
    logic              bus2ip_mst_rearbitrate;
    logic              bus2ip_mst_cmd_timeout;
    logic [DATA_W-1:0] bus2ip_mstrd_d;
    logic              bus2ip_mstrd_src_rdy_n;
    logic              bus2ip_mstwr_dst_rdy_n;

    modport master (
        output ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_be,
               ip2bus_mst_lock, ip2bus_mst_reset, ip2bus_mstwr_d,
        input  bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error,
               bus2ip_mst_rearbitrate, bus2ip_mst_cmd_timeout, bus2ip_mstrd_d,
               bus2ip_mstrd_src_rdy_n, bus2ip_mstwr_dst_rdy_n
    );

    modport slave (
        input  ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_be,
               ip2bus_mst_lock, ip2bus_mst_reset, ip2bus_mstwr_d,
        output bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error,
               bus2ip_mst_rearbitrate, bus2ip_mst_cmd_timeout, bus2ip_mstrd_d,
               bus2ip_mstrd_src_rdy_n, bus2ip_mstwr_dst_rdy_n
    );

endinterface

// File: rtl/ipif_resp_mem.sv
// DEPTH x 32 word memory: byte-enabled synchronous write, two combinational
// read ports (data path and debug backdoor).
module ipif_resp_mem
    import ipif_resp_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [BE_W-1:0]          be_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    input  logic [$clog2(DEPTH)-1:0] dbg_idx_i,
    output logic [DATA_W-1:0]        dbg_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Byte-lane write on the data beat.
    // NOTE: the array has no reset; contents must survive a bus reset, and a
    // resettable RAM cannot map onto block memory.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be_i[k]) mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    assign rdata_o    = mem_q[idx_i];
    assign dbg_data_o = mem_q[dbg_idx_i];

endmodule

// File: rtl/ipif_mst_responder.sv
// Far-end responder for the IPIF single-beat master command interface.
// Optional macro IPIF_RESP_RANGE_ERR_EN: out-of-window addresses complete
// with error and skip the data beat; otherwise addresses wrap modulo DEPTH.
module ipif_mst_responder
    import ipif_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          DEPTH      = 256,
    parameter int          LAT_CYCLES = 2
) (
    input  logic                     Bus2IP_Clk,
    input  logic                     Bus2IP_Reset,
    ipif_mst_responder_if.slave      bus,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LAT_CYCLES > 0) ? $clog2(LAT_CYCLES + 1) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic             oor_q, oor_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BE_W-1:0]  be_q, be_d;

    logic [31:0]       offset;
    logic              req_oor;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_ok;

    assign offset = bus.ip2bus_mst_addr - BASE_ADDR;
`ifdef IPIF_RESP_RANGE_ERR_EN
    assign req_oor = |offset[31:IDX_W+2];
`else
    assign req_oor = 1'b0;
`endif
    assign unused_ok = ^{1'b0, bus.ip2bus_mst_lock, offset[1:0], offset[31:IDX_W+2]};

    assign bus.bus2ip_mst_rearbitrate = 1'b0;
    assign bus.bus2ip_mst_cmd_timeout = 1'b0;

    // State and command registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            oor_q   <= oor_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
        end
    end

    // Next-state and Moore outputs; an abort overrides everything outside IDLE.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        oor_d   = oor_q;
        idx_d   = idx_q;
        be_d    = be_q;
        mem_we  = 1'b0;
        bus.bus2ip_mst_cmdack      = 1'b0;
        bus.bus2ip_mst_cmplt       = 1'b0;
        bus.bus2ip_mst_error       = 1'b0;
        bus.bus2ip_mstrd_src_rdy_n = 1'b1;
        bus.bus2ip_mstwr_dst_rdy_n = 1'b1;
        bus.bus2ip_mstrd_d         = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.ip2bus_mstrd_req || bus.ip2bus_mstwr_req) begin
                    rd_d    = bus.ip2bus_mstrd_req;   // read wins a tie
                    idx_d   = offset[IDX_W+1:2];
                    be_d    = bus.ip2bus_mst_be;
                    oor_d   = req_oor;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                bus.bus2ip_mst_cmdack = 1'b1;
                cnt_d = CNT_W'(LAT_CYCLES);
                if (LAT_CYCLES == 0) state_d = oor_q ? ST_DONE : ST_DATA;
                else                 state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) state_d = oor_q ? ST_DONE : ST_DATA;
            end
            ST_DATA: begin
                if (rd_q) begin
                    bus.bus2ip_mstrd_src_rdy_n = 1'b0;
                    bus.bus2ip_mstrd_d         = mem_rdata;
                end else begin
                    bus.bus2ip_mstwr_dst_rdy_n = 1'b0;
                    mem_we = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.bus2ip_mst_cmplt = 1'b1;
                bus.bus2ip_mst_error = oor_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.ip2bus_mst_reset && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            mem_we  = 1'b0;
            bus.bus2ip_mst_cmdack      = 1'b0;
            bus.bus2ip_mst_cmplt       = 1'b0;
            bus.bus2ip_mst_error       = 1'b0;
            bus.bus2ip_mstrd_src_rdy_n = 1'b1;
            bus.bus2ip_mstwr_dst_rdy_n = 1'b1;
            bus.bus2ip_mstrd_d         = '0;
        end
    end

    ipif_resp_mem #(.DEPTH(DEPTH)) u_mem (
        .clk        (Bus2IP_Clk),
        .we_i       (mem_we),
        .idx_i      (idx_q),
        .be_i       (be_q),
        .wdata_i    (bus.ip2bus_mstwr_d),
        .rdata_o    (mem_rdata),
        .dbg_idx_i  (dbg_addr),
        .dbg_data_o (dbg_data)
    );

endmodule
